// File: rtl/branch_cond_unit_if.sv
// Pipeline-facing bus of the branch condition unit.
// The pipeline (master) drives EX-stage operands and fetch index; the unit
// (slave) returns the resolved condition, the fetch prediction and the
// registered flush request. Statistics wires exist only with BR_STATS_EN.
interface branch_cond_unit_if #(
    parameter int WORD_LEN = 32,
    parameter int IDX_W    = 4
);
    logic [WORD_LEN-1:0] reg1;
    logic [WORD_LEN-1:0] reg2;
    logic [2:0]          br_comm;
    logic                ex_valid;
    logic                stall;
    logic [IDX_W-1:0]    ex_idx;
    logic                ex_pred;
    logic [IDX_W-1:0]    if_idx;
    logic                if_pred;
    logic                brCond;
    logic                mispredict;
    logic                redirect_taken;
`ifdef BR_STATS_EN
    logic [15:0]         br_count;
    logic [15:0]         mis_count;

    modport master (
        output reg1, reg2, br_comm, ex_valid, stall, ex_idx, ex_pred, if_idx,
        input  if_pred, brCond, mispredict, redirect_taken, br_count, mis_count
    );

    modport slave (
        input  reg1, reg2, br_comm, ex_valid, stall, ex_idx, ex_pred, if_idx,
        output if_pred, brCond, mispredict, redirect_taken, br_count, mis_count
    );
`else
    modport master (
        output reg1, reg2, br_comm, ex_valid, stall, ex_idx, ex_pred, if_idx,
        input  if_pred, brCond, mispredict, redirect_taken
    );

    modport slave (
        input  reg1, reg2, br_comm, ex_valid, stall, ex_idx, ex_pred, if_idx,
        output if_pred, brCond, mispredict, redirect_taken
    );
`endif
endinterface

// File: rtl/branch_cond_unit.sv
// Branch condition unit: resolves EX-stage branch conditions, keeps a table
// of 2-bit saturating predictors indexed by PC low bits, and raises a
// registered one-cycle mispredict pulse with the correct refetch direction.
// Optional macro BR_STATS_EN adds saturating 16-bit resolve/mispredict counters.
module branch_cond_unit #(
    parameter int WORD_LEN  = 32,
    parameter int PHT_DEPTH = 16
) (
    input logic              clk,
    input logic              rst,
    branch_cond_unit_if.slave bus
);
    localparam int IDX_W = $clog2(PHT_DEPTH);

    localparam logic [2:0] BR_JUMP = 3'b001;
    localparam logic [2:0] BR_BEQ  = 3'b010;
    localparam logic [2:0] BR_BNE  = 3'b011;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;

    logic [1:0] pht_q [PHT_DEPTH];
    logic [1:0] pht_d [PHT_DEPTH];
    logic       mispredict_q, mispredict_d;
    logic       redirect_taken_q, redirect_taken_d;

    logic       br_cond;
    logic       is_branch;
    logic       resolve;
    logic       cond_event;
    logic       mis_event;
    logic [IDX_W-1:0] ex_idx;

    assign ex_idx = bus.ex_idx;

    // Decode the branch command and evaluate its condition on the operands.
    always_comb begin
        br_cond   = 1'b0;
        is_branch = 1'b0;
        case (bus.br_comm)
            BR_JUMP: begin br_cond = 1'b1;                                   is_branch = 1'b1; end
            BR_BEQ:  begin br_cond = (bus.reg1 == bus.reg2);                 is_branch = 1'b1; end
            BR_BNE:  begin br_cond = (bus.reg1 != bus.reg2);                 is_branch = 1'b1; end
            BR_BLT:  begin br_cond = ($signed(bus.reg1) <  $signed(bus.reg2)); is_branch = 1'b1; end
            BR_BGE:  begin br_cond = ($signed(bus.reg1) >= $signed(bus.reg2)); is_branch = 1'b1; end
            default: begin br_cond = 1'b0;                                   is_branch = 1'b0; end
        endcase
    end

    assign resolve    = bus.ex_valid & ~bus.stall & is_branch;
    assign cond_event = resolve & (bus.br_comm != BR_JUMP);
    assign mis_event  = resolve & (br_cond != bus.ex_pred);

    // Next predictor table: only a conditional resolve nudges its own entry.
    always_comb begin
        for (int i = 0; i < PHT_DEPTH; i++) begin
            pht_d[i] = pht_q[i];
        end
        if (cond_event) begin
            if (br_cond && (pht_q[ex_idx] != 2'b11)) begin
                pht_d[ex_idx] = pht_q[ex_idx] + 2'd1;
            end else if (!br_cond && (pht_q[ex_idx] != 2'b00)) begin
                pht_d[ex_idx] = pht_q[ex_idx] - 2'd1;
            end
        end
    end

    // Flush request: a stalled or idle cycle clears the pulse, direction holds.
    always_comb begin
        mispredict_d     = mis_event;
        redirect_taken_d = redirect_taken_q;
        if (mis_event) begin
            redirect_taken_d = br_cond;
        end
    end

    // Predictor table registers, reset to weakly not-taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_q[i] <= pht_d[i];
            end
        end
    end

    // Mispredict pulse and refetch direction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispredict_q     <= 1'b0;
            redirect_taken_q <= 1'b0;
        end else begin
            mispredict_q     <= mispredict_d;
            redirect_taken_q <= redirect_taken_d;
        end
    end

    assign bus.brCond         = br_cond;
    assign bus.if_pred        = pht_q[bus.if_idx][1];
    assign bus.mispredict     = mispredict_q;
    assign bus.redirect_taken = redirect_taken_q;

`ifdef BR_STATS_EN
    logic [15:0] br_count_q, br_count_d;
    logic [15:0] mis_count_q, mis_count_d;

    // Saturating statistics; resolve already excludes stalled cycles.
    always_comb begin
        br_count_d  = br_count_q;
        mis_count_d = mis_count_q;
        if (resolve && (br_count_q != 16'hFFFF)) begin
            br_count_d = br_count_q + 16'd1;
        end
        if (mis_event && (mis_count_q != 16'hFFFF)) begin
            mis_count_d = mis_count_q + 16'd1;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_count_q  <= 16'd0;
            mis_count_q <= 16'd0;
        end else begin
            br_count_q  <= br_count_d;
            mis_count_q <= mis_count_d;
        end
    end

    assign bus.br_count  = br_count_q;
    assign bus.mis_count = mis_count_q;
`endif
endmodule

// File: tb/tb_branch_cond_unit.sv
// Testbench for branch_cond_unit: a condition table, hand-written corner
// sequences and randomized traffic, all checked against a behavioural model
// of the predictor table and flush pulse. Counter checks need BR_STATS_EN.
module tb_branch_cond_unit;
    localparam int WORD_LEN  = 32;
    localparam int PHT_DEPTH = 16;
    localparam int IDX_W     = 4;

    logic clk;
    logic rst;

    branch_cond_unit_if #(.WORD_LEN(WORD_LEN), .IDX_W(IDX_W)) bus ();

    branch_cond_unit #(.WORD_LEN(WORD_LEN), .PHT_DEPTH(PHT_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int pht_m [PHT_DEPTH];
    bit exp_mis;
    bit exp_red;
    int br_m;
    int mis_m;

    typedef struct {
        logic [2:0]  comm;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp;
    } vec_t;

    vec_t vecs [14];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Branch outcome from the instruction definitions.
    function automatic bit model_cond(input logic [2:0] comm, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (comm)
            3'd1:    return 1'b1;
            3'd2:    return a == b;
            3'd3:    return a != b;
            3'd4:    return sa < sb;
            3'd5:    return !(sa < sb);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PHT_DEPTH; i++) pht_m[i] = 1;
        exp_mis = 1'b0;
        exp_red = 1'b0;
        br_m    = 0;
        mis_m   = 0;
    endtask

    // Advance the model by one clock edge using the current bus inputs.
    task automatic model_edge();
        bit r;
        bit t;
        r = bus.ex_valid && !bus.stall && (bus.br_comm >= 3'd1) && (bus.br_comm <= 3'd5);
        t = model_cond(bus.br_comm, bus.reg1, bus.reg2);
        exp_mis = 1'b0;
        if (r) begin
            if (br_m < 65535) br_m++;
            if (t != bus.ex_pred) begin
                exp_mis = 1'b1;
                exp_red = t;
                if (mis_m < 65535) mis_m++;
            end
            if (bus.br_comm != 3'd1) begin
                if (t && pht_m[bus.ex_idx] < 3) pht_m[bus.ex_idx]++;
                if (!t && pht_m[bus.ex_idx] > 0) pht_m[bus.ex_idx]--;
            end
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] comm, input logic [31:0] a, input logic [31:0] b,
                                  input logic valid, input logic stl, input logic [3:0] exi,
                                  input logic pred, input logic [3:0] ifi);
        bus.br_comm  = comm;
        bus.reg1     = a;
        bus.reg2     = b;
        bus.ex_valid = valid;
        bus.stall    = stl;
        bus.ex_idx   = exi;
        bus.ex_pred  = pred;
        bus.if_idx   = ifi;
    endtask

    // Called just after a falling edge; checks combinational then registered outputs.
    task automatic check_output(input string tag);
        #1;
        check({tag, "_brCond"}, {31'd0, bus.brCond},
              {31'd0, model_cond(bus.br_comm, bus.reg1, bus.reg2)});
        check({tag, "_if_pred"}, {31'd0, bus.if_pred}, {31'd0, (pht_m[bus.if_idx] >= 2)});
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_mispredict"}, {31'd0, bus.mispredict}, {31'd0, exp_mis});
        check({tag, "_redirect"}, {31'd0, bus.redirect_taken}, {31'd0, exp_red});
`ifdef BR_STATS_EN
        check({tag, "_br_count"}, {16'd0, bus.br_count}, br_m);
        check({tag, "_mis_count"}, {16'd0, bus.mis_count}, mis_m);
`endif
        @(negedge clk);
    endtask

    task automatic idle(input logic [3:0] ifi);
        apply_stimulus(3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, ifi);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'd1, 32'd1, 1'b0};
        vecs[1]  = '{3'd1, 32'd3, 32'd9, 1'b1};
        vecs[2]  = '{3'd2, 32'd5, 32'd5, 1'b1};
        vecs[3]  = '{3'd2, 32'd5, 32'd6, 1'b0};
        vecs[4]  = '{3'd3, 32'd5, 32'd6, 1'b1};
        vecs[5]  = '{3'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{3'd4, 32'hFFFF_FFFF, 32'd1, 1'b1};
        vecs[7]  = '{3'd5, 32'hFFFF_FFFF, 32'd1, 1'b0};
        vecs[8]  = '{3'd4, 32'd1, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{3'd5, 32'd7, 32'd7, 1'b1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[11] = '{3'd5, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[12] = '{3'd6, 32'd0, 32'd0, 1'b0};
        vecs[13] = '{3'd7, 32'd1, 32'd2, 1'b0};

        rst = 1'b0;
        idle(4'd0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("reset_mispredict", {31'd0, bus.mispredict}, 32'd0);
        check("reset_redirect", {31'd0, bus.redirect_taken}, 32'd0);
        check("reset_if_pred", {31'd0, bus.if_pred}, 32'd0);
`ifdef BR_STATS_EN
        check("reset_br_count", {16'd0, bus.br_count}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Condition table with no live instruction, so no state changes.
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].comm, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
            #1;
            check($sformatf("vec%0d_brCond", i), {31'd0, bus.brCond}, {31'd0, vecs[i].exp});
            @(negedge clk);
        end

        // Taken beq against a not-taken prediction at index 3.
        idle(4'd3);
        #1;
        check("seq_a_if_pred_before", {31'd0, bus.if_pred}, 32'd0);
        @(negedge clk);
        apply_stimulus(3'd2, 32'd5, 32'd5, 1'b1, 1'b0, 4'd3, 1'b0, 4'd3);
        check_output("seq_a_beq");
        check("seq_a_mis_pulse", {31'd0, bus.mispredict}, 32'd1);
        check("seq_a_redirect", {31'd0, bus.redirect_taken}, 32'd1);
        idle(4'd3);
        #1;
        check("seq_a_if_pred_after", {31'd0, bus.if_pred}, 32'd1);
        @(negedge clk);
        check_output("seq_a_idle");

        // Saturation up then down at index 7.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(3'd3, 32'd1, 32'd2, 1'b1, 1'b0, 4'd7, 1'b1, 4'd7);
            check_output($sformatf("sat_up%0d", i));
        end
        check("sat_up_if_pred", {31'd0, bus.if_pred}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(3'd3, 32'd4, 32'd4, 1'b1, 1'b0, 4'd7, 1'b0, 4'd7);
            check_output($sformatf("sat_dn%0d", i));
        end
        check("sat_dn_if_pred", {31'd0, bus.if_pred}, 32'd0);
        // Entry at 00: one taken should leave it at 01, still predicting not-taken.
        apply_stimulus(3'd3, 32'd1, 32'd2, 1'b1, 1'b0, 4'd7, 1'b0, 4'd7);
        check_output("sat_floor");
        idle(4'd7);
        check_output("sat_floor_idle");
        check("sat_floor_if_pred", {31'd0, bus.if_pred}, 32'd0);

        // Jumps: mispredict only when predicted not-taken; table untouched.
        apply_stimulus(3'd1, 32'd0, 32'd0, 1'b1, 1'b0, 4'd5, 1'b0, 4'd5);
        check_output("jump_pred0");
        check("jump_pred0_pulse", {31'd0, bus.mispredict}, 32'd1);
        apply_stimulus(3'd1, 32'd0, 32'd0, 1'b1, 1'b0, 4'd5, 1'b1, 4'd5);
        check_output("jump_pred1");
        check("jump_pred1_pulse", {31'd0, bus.mispredict}, 32'd0);
        idle(4'd5);
        check_output("jump_idle");

        // Stalled mispredicting beq is ignored; unstalled one pulses.
        apply_stimulus(3'd2, 32'd9, 32'd8, 1'b1, 1'b1, 4'd2, 1'b1, 4'd2);
        check_output("stall_beq");
        check("stall_no_pulse", {31'd0, bus.mispredict}, 32'd0);
        apply_stimulus(3'd2, 32'd9, 32'd8, 1'b1, 1'b0, 4'd2, 1'b1, 4'd2);
        check_output("nostall_beq");
        check("nostall_pulse", {31'd0, bus.mispredict}, 32'd1);
        check("nostall_redirect", {31'd0, bus.redirect_taken}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) a = {29'd0, a[2:0]};
            apply_stimulus(3'($urandom_range(0, 7)), a, b, 1'($urandom_range(0, 3) != 0),
                           1'($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            check_output($sformatf("rand%0d", n));
        end

        // Reset asserted while a mispredict pulse is outstanding.
        apply_stimulus(3'd2, 32'd1, 32'd1, 1'b1, 1'b0, 4'd4, 1'b0, 4'd4);
        check_output("prerst_beq");
        check("prerst_pulse", {31'd0, bus.mispredict}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_mispredict", {31'd0, bus.mispredict}, 32'd0);
        check("midrst_redirect", {31'd0, bus.redirect_taken}, 32'd0);
        model_reset();
        idle(4'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < PHT_DEPTH; i++) begin
            apply_stimulus(3'd2, 32'd3, 32'd3, 1'b1, 1'b0, 4'(i), 1'b1, 4'(i));
            check_output($sformatf("postrst_up%0d", i));
            #1;
            check($sformatf("postrst_pht%0d", i), {31'd0, bus.if_pred}, 32'd1);
            @(negedge clk);
        end

`ifdef BR_STATS_EN
        // Long run of mispredicting jumps drives both counters to saturation.
        apply_stimulus(3'd1, 32'd0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        for (int n = 0; n < 70000; n++) begin
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        check("stats_br_sat", {16'd0, bus.br_count}, 32'h0000_FFFF);
        check("stats_mis_sat", {16'd0, bus.mis_count}, 32'h0000_FFFF);
        check("stats_back_to_back", {31'd0, bus.mispredict}, 32'd1);
        apply_stimulus(3'd1, 32'd0, 32'd0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0);
        check_output("stats_stall");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
